// File: rtl/prog_loader.sv
// Byte-stream loader for the CPU instruction/data ROM images. Frames are
// written while the CPU is held in reset; GO/HALT commands drive cpu_rst.
module prog_loader #(
  parameter int NWORDS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] irom_mem0,  output logic [15:0] irom_mem1,
  output logic [15:0] irom_mem2,  output logic [15:0] irom_mem3,
  output logic [15:0] irom_mem4,  output logic [15:0] irom_mem5,
  output logic [15:0] irom_mem6,  output logic [15:0] irom_mem7,
  output logic [15:0] irom_mem8,  output logic [15:0] irom_mem9,
  output logic [15:0] irom_mem10, output logic [15:0] irom_mem11,
  output logic [15:0] irom_mem12, output logic [15:0] irom_mem13,
  output logic [15:0] irom_mem14, output logic [15:0] irom_mem15,
  output logic [15:0] irom_mem16, output logic [15:0] irom_mem17,
  output logic [15:0] irom_mem18, output logic [15:0] irom_mem19,
  output logic [15:0] drom_mem0,  output logic [15:0] drom_mem1,
  output logic [15:0] drom_mem2,  output logic [15:0] drom_mem3,
  output logic [15:0] drom_mem4,  output logic [15:0] drom_mem5,
  output logic [15:0] drom_mem6,  output logic [15:0] drom_mem7,
  output logic [15:0] drom_mem8,  output logic [15:0] drom_mem9,
  output logic [15:0] drom_mem10, output logic [15:0] drom_mem11,
  output logic [15:0] drom_mem12, output logic [15:0] drom_mem13,
  output logic [15:0] drom_mem14, output logic [15:0] drom_mem15,
  output logic [15:0] drom_mem16, output logic [15:0] drom_mem17,
  output logic [15:0] drom_mem18, output logic [15:0] drom_mem19,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, ERR} state_t;

  localparam logic [5:0] NW6 = 6'(NWORDS);
  localparam logic [8:0] NW9 = 9'(NWORDS);

  state_t      state, state_next;
  logic        target;
  logic [4:0]  addr;
  logic [4:0]  remaining;
  logic [7:0]  hi_byte;
  logic [15:0] irom [NWORDS];
  logic [15:0] drom [NWORDS];

  logic fire, do_go, do_halt, load_hdr, load_cnt, latch_hi, wr, last, err_set;
  logic [8:0] frame_end;

  assign in_ready  = (state != ERR);
  assign fire      = in_valid && in_ready;
  // Range check is done wide enough that a large N can never wrap past NWORDS
  assign frame_end = {4'b0, addr} + {1'b0, in_data};

  always_comb begin
    state_next = state;
    do_go      = 1'b0;
    do_halt    = 1'b0;
    load_hdr   = 1'b0;
    load_cnt   = 1'b0;
    latch_hi   = 1'b0;
    wr         = 1'b0;
    last       = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: if (fire) begin
        if (in_data == 8'hFF) do_go = 1'b1;
        else if (in_data == 8'hFE) do_halt = 1'b1;
        else if (in_data[6:5] != 2'b00 || {1'b0, in_data[4:0]} >= NW6 || !cpu_rst) begin
          err_set    = 1'b1;
          state_next = ERR;
        end else begin
          load_hdr   = 1'b1;
          state_next = COUNT;
        end
      end
      COUNT: if (fire) begin
        if (in_data == 8'h00 || frame_end > NW9) begin
          err_set    = 1'b1;
          state_next = ERR;
        end else begin
          load_cnt   = 1'b1;
          state_next = HI;
        end
      end
      HI: if (fire) begin
        latch_hi   = 1'b1;
        state_next = LO;
      end
      LO: if (fire) begin
        wr = 1'b1;
        if (remaining == 5'd1) begin
          last       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = HI;
        end
      end
      default: state_next = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      target    <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      hi_byte   <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= last;
      err   <= err | err_set;
      if (load_hdr) begin
        target <= in_data[7];
        addr   <= in_data[4:0];
      end
      if (load_cnt) remaining <= in_data[4:0];
      if (latch_hi) hi_byte <= in_data;
      if (wr) begin
        addr      <= addr + 5'd1;
        remaining <= remaining - 5'd1;
      end
      // Any error, or sitting in ERR, pins the CPU in reset
      if (err_set || state == ERR) cpu_rst <= 1'b1;
      else if (do_go)              cpu_rst <= 1'b0;
      else if (do_halt)            cpu_rst <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NWORDS; i++) begin
        irom[i] <= '0;
        drom[i] <= '0;
      end
    end else if (wr) begin
      if (target) drom[addr] <= {hi_byte, in_data};
      else        irom[addr] <= {hi_byte, in_data};
    end
  end

  assign irom_mem0  = irom[0];  assign irom_mem1  = irom[1];
  assign irom_mem2  = irom[2];  assign irom_mem3  = irom[3];
  assign irom_mem4  = irom[4];  assign irom_mem5  = irom[5];
  assign irom_mem6  = irom[6];  assign irom_mem7  = irom[7];
  assign irom_mem8  = irom[8];  assign irom_mem9  = irom[9];
  assign irom_mem10 = irom[10]; assign irom_mem11 = irom[11];
  assign irom_mem12 = irom[12]; assign irom_mem13 = irom[13];
  assign irom_mem14 = irom[14]; assign irom_mem15 = irom[15];
  assign irom_mem16 = irom[16]; assign irom_mem17 = irom[17];
  assign irom_mem18 = irom[18]; assign irom_mem19 = irom[19];
  assign drom_mem0  = drom[0];  assign drom_mem1  = drom[1];
  assign drom_mem2  = drom[2];  assign drom_mem3  = drom[3];
  assign drom_mem4  = drom[4];  assign drom_mem5  = drom[5];
  assign drom_mem6  = drom[6];  assign drom_mem7  = drom[7];
  assign drom_mem8  = drom[8];  assign drom_mem9  = drom[9];
  assign drom_mem10 = drom[10]; assign drom_mem11 = drom[11];
  assign drom_mem12 = drom[12]; assign drom_mem13 = drom[13];
  assign drom_mem14 = drom[14]; assign drom_mem15 = drom[15];
  assign drom_mem16 = drom[16]; assign drom_mem17 = drom[17];
  assign drom_mem18 = drom[18]; assign drom_mem19 = drom[19];

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: loads, GO/HALT, error cases
// and asynchronous reset in the middle of a frame.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, cpu_rst, done, err;
  logic [15:0] irom [20];
  logic [15:0] drom [20];

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  prog_loader #(.NWORDS(20)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .irom_mem0(irom[0]),   .irom_mem1(irom[1]),   .irom_mem2(irom[2]),   .irom_mem3(irom[3]),
    .irom_mem4(irom[4]),   .irom_mem5(irom[5]),   .irom_mem6(irom[6]),   .irom_mem7(irom[7]),
    .irom_mem8(irom[8]),   .irom_mem9(irom[9]),   .irom_mem10(irom[10]), .irom_mem11(irom[11]),
    .irom_mem12(irom[12]), .irom_mem13(irom[13]), .irom_mem14(irom[14]), .irom_mem15(irom[15]),
    .irom_mem16(irom[16]), .irom_mem17(irom[17]), .irom_mem18(irom[18]), .irom_mem19(irom[19]),
    .drom_mem0(drom[0]),   .drom_mem1(drom[1]),   .drom_mem2(drom[2]),   .drom_mem3(drom[3]),
    .drom_mem4(drom[4]),   .drom_mem5(drom[5]),   .drom_mem6(drom[6]),   .drom_mem7(drom[7]),
    .drom_mem8(drom[8]),   .drom_mem9(drom[9]),   .drom_mem10(drom[10]), .drom_mem11(drom[11]),
    .drom_mem12(drom[12]), .drom_mem13(drom[13]), .drom_mem14(drom[14]), .drom_mem15(drom[15]),
    .drom_mem16(drom[16]), .drom_mem17(drom[17]), .drom_mem18(drom[18]), .drom_mem19(drom[19]),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  // The clock can be frozen so reset can be exercised between edges
  always #5 clk = clk_en ? ~clk : clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    #7;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (irom[i] !== 16'h0000 || drom[i] !== 16'h0000) begin
        tests_failed++; bad++;
        $display("[TB] FAIL reset_mem[%0d]: irom=%h drom=%h expected 0000", i, irom[i], drom[i]);
      end
    end
    tests_run++;
    if ({cpu_rst, in_ready, done, err} !== 4'b1100) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: {cpu_rst,in_ready,done,err}=%b expected 1100", {cpu_rst, in_ready, done, err});
    end
  endtask

  task automatic test_single_word();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h60);
    done_cnt = 0;
    send_byte(8'h24);
    tests_run++;
    if (irom[0] !== 16'h6024) begin
      tests_failed++; $display("[TB] FAIL single_irom0: got %h expected 6024", irom[0]);
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL single_done_hi: got %b expected 1", done);
    end
    idle_cycle();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL single_done_lo: got %b expected 0", done);
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++; $display("[TB] FAIL single_done_cnt: got %0d expected 1", done_cnt);
    end
    tests_run++;
    if (irom[1] !== 16'h0000 || drom[0] !== 16'h0000) begin
      tests_failed++; $display("[TB] FAIL single_others: irom1=%h drom0=%h expected 0000", irom[1], drom[0]);
    end
  endtask

  task automatic test_full_drom();
    logic [15:0] w;
    do_reset();
    send_byte(8'h80); idle_cycle();
    send_byte(8'h14); idle_cycle();
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      w = 16'h0100 + 16'(i);
      send_byte(w[15:8]); idle_cycle();
      send_byte(w[7:0]);  idle_cycle();
    end
    idle_cycle(); idle_cycle();
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (drom[i] !== 16'h0100 + 16'(i)) begin
        tests_failed++;
        $display("[TB] FAIL full_drom[%0d]: got %h expected %h", i, drom[i], 16'h0100 + 16'(i));
      end
    end
    tests_run++;
    if (done_cnt !== 1 || err !== 1'b0 || irom[0] !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL full_status: done_cnt=%0d err=%b irom0=%h expected 1/0/0000", done_cnt, err, irom[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h83); send_byte(8'h02); send_byte(8'hA0); send_byte(8'h01);
    send_byte(8'hA0); send_byte(8'h02);
    tests_run++;
    if (irom[2] !== 16'h1111 || drom[3] !== 16'hA001 || drom[4] !== 16'hA002 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b: irom2=%h drom3=%h drom4=%h err=%b expected 1111/A001/A002/0",
               irom[2], drom[3], drom[4], err);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    send_byte(8'h13); send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
    tests_run++;
    if (irom[19] !== 16'hFFFF || err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL bound_a19: irom19=%h err=%b expected FFFF/0", irom[19], err);
    end
    send_byte(8'h13);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL bound_hdr_ok: err=%b expected 0", err);
    end
    send_byte(8'h02);
    tests_run++;
    if (err !== 1'b1 || in_ready !== 1'b0 || irom[19] !== 16'hFFFF || cpu_rst !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bound_overflow: err=%b in_ready=%b irom19=%h cpu_rst=%b expected 1/0/FFFF/1",
               err, in_ready, irom[19], cpu_rst);
    end
    in_data = 8'h00; in_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    tests_run++;
    if (err !== 1'b1 || irom[19] !== 16'hFFFF || irom[0] !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL bound_err_sticky: err=%b irom19=%h irom0=%h expected 1/FFFF/0000", err, irom[19], irom[0]);
    end
  endtask

  task automatic test_go_halt();
    do_reset();
    send_byte(8'hFF);
    tests_run++;
    if (cpu_rst !== 1'b0 || done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL go: cpu_rst=%b done=%b expected 0/0", cpu_rst, done);
    end
    send_byte(8'h00);
    tests_run++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_while_running: err=%b cpu_rst=%b in_ready=%b expected 1/1/0", err, cpu_rst, in_ready);
    end
    do_reset();
    send_byte(8'hFF);
    tests_run++;
    if (cpu_rst !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL go2: cpu_rst=%b expected 0", cpu_rst);
    end
    send_byte(8'hFE);
    tests_run++;
    if (cpu_rst !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL halt: cpu_rst=%b err=%b done=%b expected 1/0/0", cpu_rst, err, done);
    end
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h5A); send_byte(8'hA5); send_byte(8'hFF);
    tests_run++;
    if (irom[1] !== 16'h5AA5 || cpu_rst !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reload_go: irom1=%h cpu_rst=%b err=%b expected 5AA5/0/0", irom[1], cpu_rst, err);
    end
  endtask

  task automatic test_errors();
    do_reset();
    send_byte(8'h20);
    tests_run++;
    if (err !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL err_bits65: err=%b in_ready=%b expected 1/0", err, in_ready);
    end
    do_reset();
    send_byte(8'h00);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL err_n0_hdr: err=%b expected 0", err);
    end
    send_byte(8'h00);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL err_n0: err=%b expected 1", err);
    end
    do_reset();
    send_byte(8'h14);
    tests_run++;
    if (err !== 1'b1 || cpu_rst !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL err_a20: err=%b cpu_rst=%b expected 1/1", err, cpu_rst);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_byte(8'h05); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    clk_en = 1'b0;
    #10;
    rst = 1'b0;
    #2;
    tests_run++;
    if (irom[5] !== 16'h0000 || cpu_rst !== 1'b1 || in_ready !== 1'b1 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_clear: irom5=%h cpu_rst=%b in_ready=%b err=%b expected 0000/1/1/0",
               irom[5], cpu_rst, in_ready, err);
    end
    rst = 1'b1;
    #2;
    clk_en = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h34); send_byte(8'h56);
    tests_run++;
    if (irom[0] !== 16'h3456 || irom[1] !== 16'h0000 || done !== 1'b1 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reload: irom0=%h irom1=%h done=%b err=%b expected 3456/0000/1/0",
               irom[0], irom[1], done, err);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_drom();
    test_back_to_back();
    test_boundary();
    test_go_halt();
    test_errors();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
